// File: rtl/cosmic_snd_pkg.sv
// Shared constants and types for the Cosmic sound-port trigger block.
// Used by cosmic_sound_trigger; see that file for the COSMIC_SNDTRIG_HOLDOFF_EN option.
package cosmic_snd_pkg;

  localparam int NUM_CH = 16;

  localparam logic [1:0] SND_PORT_LO = 2'd0;
  localparam logic [1:0] SND_PORT_HI = 2'd1;
  localparam logic [1:0] SND_PORT_EN = 2'd2;

  typedef logic [15:0] snd_vec_t;

endpackage

// File: rtl/cosmic_sndtrig_chan.sv
// One sound channel: trigger pulse, stop pulse and (with COSMIC_SNDTRIG_HOLDOFF_EN)
// a retrigger holdoff timer. All timers are saturating down-counters frozen by paused_i.
module cosmic_sndtrig_chan #(
  parameter int PULSE_LEN = 4
`ifdef COSMIC_SNDTRIG_HOLDOFF_EN
  , parameter int HOLDOFF = 2048
`endif
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic paused_i,
  input  logic rise_i,
  input  logic fall_i,
  input  logic loop_i,
  input  logic en_drop_i,
  output logic trig_o,
  output logic stop_o
);

  localparam int PW = $clog2(PULSE_LEN + 1);
  localparam logic [PW-1:0] PULSE_INIT = PW'(PULSE_LEN);

  logic [PW-1:0] pulse_q, pulse_d;
  logic [PW-1:0] stop_q, stop_d;
  logic          take;

`ifdef COSMIC_SNDTRIG_HOLDOFF_EN
  localparam int HW = $clog2(HOLDOFF + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLDOFF);

  logic [HW-1:0] hold_q, hold_d;

  // A rising edge inside the holdoff window is dropped, never queued.
  assign take = rise_i && (hold_q == '0);

  always_comb begin
    hold_d = hold_q;
    if (hold_q != '0 && !paused_i) hold_d = hold_q - HW'(1);
    if (take) hold_d = HOLD_INIT;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) hold_q <= '0;
    else         hold_q <= hold_d;
  end
`else
  assign take = rise_i;
`endif

  always_comb begin
    pulse_d = pulse_q;
    stop_d  = stop_q;
    if (!paused_i) begin
      if (pulse_q != '0) pulse_d = pulse_q - PW'(1);
      if (stop_q != '0)  stop_d  = stop_q - PW'(1);
    end
    if (take) begin
      pulse_d = PULSE_INIT;
      stop_d  = '0;
    end
    if ((fall_i && loop_i) || en_drop_i) begin
      stop_d  = PULSE_INIT;
      pulse_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pulse_q <= '0;
      stop_q  <= '0;
    end else begin
      pulse_q <= pulse_d;
      stop_q  <= stop_d;
    end
  end

  assign trig_o = (pulse_q != '0);
  assign stop_o = (stop_q != '0);

endmodule

// File: rtl/cosmic_sound_trigger.sv
// Turns Cosmic sound-port writes into stretched trigger/stop pulses for the samples player.
// Define COSMIC_SNDTRIG_HOLDOFF_EN to enable per-channel retrigger holdoff.
module cosmic_sound_trigger #(
  parameter int          NUM_CH    = cosmic_snd_pkg::NUM_CH,
  parameter int          PULSE_LEN = 4,
  parameter int          HOLDOFF   = 2048,
  parameter logic [15:0] LOOP_MASK = 16'h0000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        PAUSED,
  input  logic        I_WR,
  input  logic [1:0]  I_ADDR,
  input  logic [7:0]  I_DATA,
  output logic [15:0] O_TRIGGER,
  output logic [15:0] O_STOP,
  output logic [15:0] O_LATCH,
  output logic        O_SOUND_EN
);

  import cosmic_snd_pkg::*;

  snd_vec_t latch_q, latch_d;
  snd_vec_t rise, fall;
  logic     en_q, en_d;
  logic     en_drop;

  always_comb begin
    latch_d = latch_q;
    en_d    = en_q;
    if (I_WR) begin
      case (I_ADDR)
        SND_PORT_LO: latch_d[7:0]  = I_DATA;
        SND_PORT_HI: latch_d[15:8] = I_DATA;
        SND_PORT_EN: en_d          = I_DATA[0];
        default: ;
      endcase
    end
  end

  // Edges compare the incoming byte against the latch as it was before this write.
  assign rise    = latch_d & ~latch_q;
  assign fall    = ~latch_d & latch_q;
  assign en_drop = en_q & ~en_d;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      latch_q <= '0;
      en_q    <= 1'b1;
    end else begin
      latch_q <= latch_d;
      en_q    <= en_d;
    end
  end

`ifndef COSMIC_SNDTRIG_HOLDOFF_EN
  localparam int unused_holdoff = HOLDOFF;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    cosmic_sndtrig_chan #(
      .PULSE_LEN(PULSE_LEN)
`ifdef COSMIC_SNDTRIG_HOLDOFF_EN
      , .HOLDOFF(HOLDOFF)
`endif
    ) u_chan (
      .clk_i     (CLK),
      .rst_ni    (RESET_N),
      .paused_i  (PAUSED),
      .rise_i    (rise[i] & en_q),
      .fall_i    (fall[i]),
      .loop_i    (LOOP_MASK[i]),
      .en_drop_i (en_drop),
      .trig_o    (O_TRIGGER[i]),
      .stop_o    (O_STOP[i])
    );
  end

  assign O_LATCH    = latch_q;
  assign O_SOUND_EN = en_q;

endmodule

// File: tb/tb_cosmic_sound_trigger.sv
// Self-checking bench for cosmic_sound_trigger: directed writes, an elapsed-time model
// compared every cycle, and literal pulse-length/count expectations.
module tb_cosmic_sound_trigger;

  localparam int          PL = 4;
  localparam int          HO = 2048;
  localparam logic [15:0] LM = 16'h0100;
`ifdef COSMIC_SNDTRIG_HOLDOFF_EN
  localparam bit HE = 1'b1;
`else
  localparam bit HE = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET_N, PAUSED, I_WR;
  logic [1:0]  I_ADDR;
  logic [7:0]  I_DATA;
  logic [15:0] O_TRIGGER, O_STOP, O_LATCH;
  logic        O_SOUND_EN;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  cosmic_sound_trigger #(
    .PULSE_LEN(PL), .HOLDOFF(HO), .LOOP_MASK(LM)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .PAUSED(PAUSED), .I_WR(I_WR),
    .I_ADDR(I_ADDR), .I_DATA(I_DATA), .O_TRIGGER(O_TRIGGER),
    .O_STOP(O_STOP), .O_LATCH(O_LATCH), .O_SOUND_EN(O_SOUND_EN)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: remaining high cycles per pulse, and unpaused cycles elapsed since the last
  // accepted trigger on each channel.
  int          trig_rem[16];
  int          stop_rem[16];
  int          since[16];
  logic [15:0] m_latch;
  logic        m_en;

  task automatic model_reset();
    m_latch = '0;
    m_en    = 1'b1;
    for (int i = 0; i < 16; i++) begin
      trig_rem[i[3:0]] = 0;
      stop_rem[i[3:0]] = 0;
      since[i[3:0]]    = HO;
    end
  endtask

  task automatic model_cycle(input bit w, input logic [1:0] a, input logic [7:0] d, input bit p);
    logic [15:0] nl;
    logic        ne;
    bit          ok;
    nl = m_latch;
    ne = m_en;
    if (w) begin
      case (a)
        2'd0: nl[7:0]  = d;
        2'd1: nl[15:8] = d;
        2'd2: ne       = d[0];
        default: ;
      endcase
    end
    for (int i = 0; i < 16; i++) begin
      ok = !HE || (since[i[3:0]] >= HO);
      if (!p) begin
        if (trig_rem[i[3:0]] > 0) trig_rem[i[3:0]]--;
        if (stop_rem[i[3:0]] > 0) stop_rem[i[3:0]]--;
        if (since[i[3:0]] < HO)   since[i[3:0]]++;
      end
      if (nl[i[3:0]] && !m_latch[i[3:0]] && m_en && ok) begin
        trig_rem[i[3:0]] = PL;
        stop_rem[i[3:0]] = 0;
        since[i[3:0]]    = 0;
      end
      if ((!nl[i[3:0]] && m_latch[i[3:0]] && LM[i[3:0]]) || (m_en && !ne)) begin
        stop_rem[i[3:0]] = PL;
        trig_rem[i[3:0]] = 0;
      end
    end
    m_latch = nl;
    m_en    = ne;
  endtask

  logic [15:0] et, es;
  initial forever begin
    @(negedge CLK);
    if (RESET_N) begin
      for (int i = 0; i < 16; i++) begin
        et[i[3:0]] = (trig_rem[i[3:0]] > 0);
        es[i[3:0]] = (stop_rem[i[3:0]] > 0);
      end
      chk("cyc_trigger", O_TRIGGER, et);
      chk("cyc_stop", O_STOP, es);
      chk("cyc_latch", O_LATCH, m_latch);
      chk("cyc_enable", O_SOUND_EN, m_en);
    end
  end

  logic [3:0] obs_ch;
  int hi_t, pulses_t, hi_s, pulses_s;
  bit prev_t, prev_s;

  task automatic obs_reset(input logic [3:0] ch);
    obs_ch   = ch;
    hi_t     = 0;
    pulses_t = 0;
    hi_s     = 0;
    pulses_s = 0;
    prev_t   = O_TRIGGER[ch];
    prev_s   = O_STOP[ch];
  endtask

  // One clock cycle: drive a (possibly idle) write, advance the model at the edge,
  // then tally the observed channel on the following negedge.
  task automatic step(input bit w, input logic [1:0] a, input logic [7:0] d);
    I_WR   = w;
    I_ADDR = a;
    I_DATA = d;
    @(posedge CLK);
    model_cycle(w, a, d, PAUSED);
    @(negedge CLK);
    I_WR = 1'b0;
    if (O_TRIGGER[obs_ch] && !prev_t) pulses_t++;
    if (O_TRIGGER[obs_ch]) hi_t++;
    if (O_STOP[obs_ch] && !prev_s) pulses_s++;
    if (O_STOP[obs_ch]) hi_s++;
    prev_t = O_TRIGGER[obs_ch];
    prev_s = O_STOP[obs_ch];
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 2'd0, 8'h00);
  endtask

  initial begin
    RESET_N = 1'b0;
    PAUSED  = 1'b0;
    I_WR    = 1'b0;
    I_ADDR  = 2'd0;
    I_DATA  = 8'h00;
    obs_ch  = 4'd0;
    model_reset();
    repeat (3) @(negedge CLK);
    chk("reset_trigger", O_TRIGGER, 16'h0000);
    chk("reset_stop", O_STOP, 16'h0000);
    chk("reset_latch", O_LATCH, 16'h0000);
    chk("reset_enable", O_SOUND_EN, 1'b1);
    RESET_N = 1'b1;

    // basic trigger on bit 0
    obs_reset(4'd0);
    step(1'b1, 2'd0, 8'h01);
    chk("basic_latch", O_LATCH, 16'h0001);
    idle(7);
    chk("basic_trig_len", hi_t, 4);
    chk("basic_trig_count", pulses_t, 1);
    chk("basic_no_stop", hi_s, 0);
    step(1'b1, 2'd3, 8'hFF);
    step(1'b1, 2'd0, 8'h01);
    chk("rewrite_no_pulse", O_TRIGGER, 16'h0000);

    // holdoff on bit 1
    obs_reset(4'd1);
    step(1'b1, 2'd0, 8'h03); idle(19);
    step(1'b1, 2'd0, 8'h01); idle(19);
    step(1'b1, 2'd0, 8'h03); idle(19);
    chk("holdoff_burst_pulses", pulses_t, HE ? 1 : 2);
    idle(2100);
    obs_reset(4'd1);
    step(1'b1, 2'd0, 8'h01); idle(5);
    step(1'b1, 2'd0, 8'h03); idle(8);
    chk("holdoff_after_pulses", pulses_t, 1);
    chk("holdoff_after_len", hi_t, 4);

    // holdoff boundary: bits 2 and 4 triggered together at cycle N
    step(1'b1, 2'd0, 8'h17);
    chk("multi_bit_trig", O_TRIGGER[4:2], 3'b101);
    idle(8);
    step(1'b1, 2'd0, 8'h03);
    idle(2038);
    step(1'b1, 2'd0, 8'h07);
    chk("holdoff_edge_n_plus_h", O_TRIGGER[2], HE ? 1'b0 : 1'b1);
    step(1'b1, 2'd0, 8'h17);
    chk("holdoff_edge_n_plus_h1", O_TRIGGER[4], 1'b1);
    idle(6);

    // loop stop on bit 8, none on bit 9
    obs_reset(4'd8);
    step(1'b1, 2'd1, 8'h01); idle(6);
    step(1'b1, 2'd1, 8'h00); idle(8);
    chk("loop8_trig_count", pulses_t, 1);
    chk("loop8_trig_len", hi_t, 4);
    chk("loop8_stop_count", pulses_s, 1);
    chk("loop8_stop_len", hi_s, 4);
    obs_reset(4'd9);
    step(1'b1, 2'd1, 8'h02); idle(6);
    step(1'b1, 2'd1, 8'h00); idle(8);
    chk("loop9_trig_count", pulses_t, 1);
    chk("loop9_no_stop", hi_s, 0);

    // enable drop and re-enable
    obs_reset(4'd3);
    step(1'b1, 2'd2, 8'h00);
    chk("en_drop_stop_all", O_STOP, 16'hFFFF);
    chk("en_drop_enable", O_SOUND_EN, 1'b0);
    idle(7);
    chk("en_drop_stop_len", hi_s, 4);
    obs_reset(4'd3);
    step(1'b1, 2'd0, 8'h1F); idle(6);
    chk("disabled_no_trig", pulses_t, 0);
    step(1'b1, 2'd2, 8'h01);
    chk("en_on_no_pulse", {O_TRIGGER, O_STOP}, 32'h0);
    step(1'b1, 2'd0, 8'h17);
    obs_reset(4'd3);
    step(1'b1, 2'd0, 8'h1F); idle(6);
    chk("reenabled_trig_count", pulses_t, 1);
    chk("reenabled_trig_len", hi_t, 4);

    // pause freeze on bit 5, with a write accepted while paused
    obs_reset(4'd5);
    step(1'b1, 2'd0, 8'h3F);
    step(1'b0, 2'd0, 8'h00);
    PAUSED = 1'b1;
    idle(4);
    step(1'b1, 2'd0, 8'h7F);
    idle(5);
    PAUSED = 1'b0;
    idle(10);
    chk("pause_trig_len", hi_t, 14);
    chk("pause_trig_count", pulses_t, 1);
    chk("pause_write_latch", O_LATCH, 16'h007F);

    // reset in the middle of a pulse
    step(1'b1, 2'd0, 8'h7E);
    step(1'b1, 2'd0, 8'h7F);
    step(1'b0, 2'd0, 8'h00);
    chk("pre_reset_pulse", O_TRIGGER[0], 1'b1);
    #1;
    RESET_N = 1'b0;
    model_reset();
    #1;
    chk("async_reset_trigger", O_TRIGGER, 16'h0000);
    chk("async_reset_stop", O_STOP, 16'h0000);
    chk("async_reset_latch", O_LATCH, 16'h0000);
    @(negedge CLK);
    RESET_N = 1'b1;
    obs_reset(4'd0);
    step(1'b1, 2'd0, 8'h01); idle(6);
    chk("post_reset_trig_count", pulses_t, 1);
    chk("post_reset_trig_len", hi_t, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cosmic_sound_trigger.md
# cosmic_sound_trigger

Converts CPU writes to the Cosmic sound ports into clean trigger and stop pulses for the samples player. It sits between the COSMIC core's sound-port writes and the samples module's trigger and stop inputs.

- Each of 16 latched sound bits is edge-detected.
- Trigger and stop pulses are stretched to a fixed length.
- Per-channel holdoff rate-limits retriggering.
- A global enable mutes everything.
- Pulse and holdoff timing freezes while the CPU is paused.

## Interface
Parameters:
- NUM_CH, 16: number of sound channels (fixed to 16 by the port map, two 8-bit ports).
- PULSE_LEN, 4: trigger/stop pulse width in CLK cycles; must be at least 1.
- HOLDOFF, 2048: minimum CLK cycles between accepted triggers on one channel; must be at least 1.
- LOOP_MASK, 16'h0000: channels whose falling edge produces a stop pulse.

Ports:
- CLK, in, 1: system clock (clk_sys).
- RESET_N, in, 1: asynchronous, active-low reset.
- PAUSED, in, 1: freezes all counters while high.
- I_WR, in, 1: one-cycle sound-port write strobe.
- I_ADDR, in, 2: port select.
  - 0: bits 7:0.
  - 1: bits 15:8.
  - 2: enable register (bit 0).
  - 3: ignored.
- I_DATA, in, 8: write data.
- O_TRIGGER, out, 16: per-channel trigger pulses.
- O_STOP, out, 16: per-channel stop pulses.
- O_LATCH, out, 16: current latched sound bits.
- O_SOUND_EN, out, 1: global enable.

## Operation
- **Reset values:** O_TRIGGER=0, O_STOP=0, O_LATCH=0, O_SOUND_EN=1. All pulse and holdoff counters are 0.
- **Port writes:** a write to address 0 or 1 replaces the matching latch byte. A write to address 2 sets O_SOUND_EN to I_DATA[0]. Writes are accepted even while PAUSED.
- **Trigger (channel i):** taken on a rising edge (new bit 1, old bit 0) when:
  - O_SOUND_EN=1, and
  - the holdoff counter for channel i is 0.
- **Trigger actions:** load the pulse counter with PULSE_LEN, load holdoff with HOLDOFF, and clear any active stop pulse on i.
- **Blocked trigger:** a rising edge arriving during holdoff or with O_SOUND_EN=0 is dropped, never queued.
- **Stop (channel i):** a falling edge with LOOP_MASK[i]=1 loads the stop counter with PULSE_LEN and clears any active trigger pulse on i.
- **Enable 1→0:** all 16 stop counters load PULSE_LEN, and all trigger pulses clear.
- **Enable 0→1:** no pulses are generated.
- **Output derivation:** O_TRIGGER[i] = (pulse counter ≠ 0); O_STOP[i] = (stop counter ≠ 0).
- **Counter widths:**
  - Pulse counters: $clog2(PULSE_LEN+1) bits.
  - Holdoff counters: $clog2(HOLDOFF+1) bits.
  - All counters decrement by 1 per CLK while nonzero and not PAUSED, and saturate at 0.
- **PAUSED=1:** all counters hold and outputs hold. Edge loads still occur, and a load overrides the held value.
- **Same-cycle load and decrement:** the load wins.

## Timing
- **Write latency:** write strobe in cycle N → O_LATCH updated at the edge ending N.
- **Pulse timing:** edge detection compares I_DATA with the pre-write latch in cycle N. O_TRIGGER/O_STOP assert in cycle N+1 and stay high exactly PULSE_LEN unpaused cycles.
- **Holdoff window:** the next trigger on the same channel is accepted only if its write cycle is ≥ N+HOLDOFF+1, counting unpaused cycles.
- **Rewrites:** rewriting the same value causes no edge and no pulse. Multiple bits toggling in one write are handled independently in the same cycle.
- **Reset mid-operation:** all pulses drop immediately and asynchronously. After RESET_N deasserts, the first write behaves as if coming from latch=0.

## Configuration
- **COSMIC_SNDTRIG_HOLDOFF_EN defined:** the holdoff counters and blocking are present as described.
- **Macro undefined:**
  - No holdoff registers exist.
  - Every qualifying rising edge triggers.
  - A rising edge during an active trigger pulse reloads the pulse counter to PULSE_LEN, so the pulse extends without a low gap.
  - The HOLDOFF parameter is ignored.

## Structure
- **Shared package cosmic_snd_pkg:**
  - NUM_CH constant.
  - Port address localparams SND_PORT_LO=0, SND_PORT_HI=1, SND_PORT_EN=2.
  - Typedef snd_vec_t (logic [15:0]).
- **Sub-module cosmic_sndtrig_chan:** one channel holding the pulse counter, stop counter and optional holdoff counter. It is instantiated NUM_CH times by a generate loop. Its inputs are rise, fall, loop, enable-drop and PAUSED; its outputs are trig and stop.

## Test plan
- **Basic trigger:** reset, then write addr 0 = 8'h01 → O_LATCH=16'h0001 next cycle, O_TRIGGER[0] high exactly 4 cycles, O_STOP=0.
- **Holdoff:** write 8'h01, 8'h00, 8'h01 within 100 cycles (HOLDOFF=2048) → exactly one trigger pulse. Repeat after 2100 cycles → second pulse.
- **Loop stop:** with LOOP_MASK=16'h0100, write addr 1 = 8'h01 then 8'h00 → O_TRIGGER[8] pulse, then O_STOP[8] pulse of 4 cycles. The same sequence on bit 9 gives no stop.
- **Enable drop:** write addr 2 = 0 → O_STOP=16'hFFFF for 4 cycles. A subsequent rise on bit 3 gives no trigger. After re-enable, a rise on bit 3 triggers.
- **Pause freeze:** trigger bit 5, then hold PAUSED for 10 cycles after the first pulse cycle → O_TRIGGER[5] is high 14 cycles total.
- **Reset mid-pulse:** assert RESET_N low during a pulse → all outputs 0 immediately. After release, a write of 8'h01 triggers even though holdoff had been active.
